// File: rtl/player_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : player_sprite_drawer
// Purpose  : Erases the old player sprite and paints the new one, one pixel
//            per clock, on the VGA adapter's pixel-plot interface.
// Revision : 1.0
// ============================================================================
module player_sprite_drawer #(
    parameter int          LANE_W        = 32,
    parameter int          SPR_W         = 16,
    parameter int          SPR_H         = 12,
    parameter int          Y_TOP         = 100,
    parameter logic [2:0]  PLAYER_COLOUR = 3'b010,
    parameter logic [2:0]  BG_COLOUR     = 3'b000,
    parameter int          RESET_LANE    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] lane,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int C_CX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int C_CY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [C_CX_W-1:0] C_LAST_CX    = C_CX_W'(SPR_W - 1);
    localparam logic [C_CY_W-1:0] C_LAST_CY    = C_CY_W'(SPR_H - 1);
    localparam logic [7:0]        C_X_OFF      = 8'((LANE_W - SPR_W) / 2);
    localparam logic [6:0]        C_Y_TOP      = 7'(Y_TOP);
    localparam logic [2:0]        C_RESET_LANE = 3'(RESET_LANE);
    localparam logic [2:0]        C_MAX_LANE   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          target_lane_q, target_lane_d;
    logic [2:0]          drawn_lane_q, drawn_lane_d;
    logic [C_CX_W-1:0]   cx_q, cx_d;
    logic [C_CY_W-1:0]   cy_q, cy_d;

    logic                w_last_pixel;
    logic [2:0]          w_lane_sel;
    logic [7:0]          w_base_x;

    // Reset lands in DRAW so the sprite is painted once without a prior erase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_DRAW;
            target_lane_q <= C_RESET_LANE;
            drawn_lane_q  <= C_RESET_LANE;
            cx_q          <= '0;
            cy_q          <= '0;
        end else begin
            state_q       <= state_d;
            target_lane_q <= target_lane_d;
            drawn_lane_q  <= drawn_lane_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
        end
    end

    assign w_last_pixel = (cx_q == C_LAST_CX) && (cy_q == C_LAST_CY);

    always_comb begin
        state_d       = state_q;
        target_lane_d = target_lane_q;
        drawn_lane_d  = drawn_lane_q;
        cx_d          = cx_q;
        cy_d          = cy_q;

        // Row-major scan shared by ERASE and DRAW.
        if (state_q == S_ERASE || state_q == S_DRAW) begin
            if (cx_q == C_LAST_CX) begin
                cx_d = '0;
                cy_d = cy_q + C_CY_W'(1);
            end else begin
                cx_d = cx_q + C_CX_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if ((lane <= C_MAX_LANE) && (lane != drawn_lane_q)) begin
                    target_lane_d = lane;
                    cx_d          = '0;
                    cy_d          = '0;
                    state_d       = S_ERASE;
                end
            end
            S_ERASE: begin
                if (w_last_pixel) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_last_pixel) begin
                    drawn_lane_d = target_lane_q;
                    cx_d         = '0;
                    cy_d         = '0;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_lane_sel = (state_q == S_ERASE) ? drawn_lane_q : target_lane_q;
    assign w_base_x   = 8'(32'(w_lane_sel) * LANE_W) + C_X_OFF;

    // Outputs are gated by reset so the plot strobe drops without waiting for a clock.
    always_comb begin
        x      = '0;
        y      = '0;
        colour = BG_COLOUR;
        plot   = 1'b0;
        if (!reset && (state_q == S_ERASE || state_q == S_DRAW)) begin
            x      = w_base_x + 8'(cx_q);
            y      = C_Y_TOP + 7'(cy_q);
            colour = (state_q == S_ERASE) ? BG_COLOUR : PLAYER_COLOUR;
            plot   = 1'b1;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = !reset && (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_player_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_sprite_drawer
// Purpose  : Scoreboard bench for player_sprite_drawer; expected pixels and
//            done pulses, each stamped with its cycle, are queued by stimulus.
// Revision : 1.0
// ============================================================================
module tb_player_sprite_drawer;

    logic       clk;
    logic       reset;
    logic [2:0] lane;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    player_sprite_drawer dut (
        .clk    (clk),
        .reset  (reset),
        .lane   (lane),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        int kind;   // 0 = pixel, 1 = done pulse
        int px;
        int py;
        int col;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   plot_cnt = 0;
    int   done_cnt = 0;

    // Hand-computed left edges of the sprite in each lane.
    int c_base[5] = '{8, 40, 72, 104, 136};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every plot or done cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (plot) plot_cnt++;
            if (done) done_cnt++;
            if (plot || done) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("kind", done ? 1 : 0, e.kind);
                    chk("cycle", cyc, e.cyc);
                    if (e.kind == 0) begin
                        chk("x", int'(x), e.px);
                        chk("y", int'(y), e.py);
                        chk("colour", int'(colour), e.col);
                        chk("busy_while_plot", int'(busy), 1);
                    end
                end
            end
        end
    end

    task automatic push_phase(input int l, input int col, input int start);
        for (int cy = 0; cy < 12; cy++) begin
            for (int cx = 0; cx < 16; cx++) begin
                exp_t e;
                e.kind = 0; e.px = c_base[l] + cx; e.py = 100 + cy;
                e.col = col; e.cyc = start + cy * 16 + cx;
                q.push_back(e);
            end
        end
    endtask

    task automatic push_done(input int c);
        exp_t e;
        e.kind = 1; e.px = 0; e.py = 0; e.col = 0; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic push_redraw(input int from, input int to, input int n);
        push_phase(from, 0, n);
        push_phase(to, 2, n + 192);
        push_done(n + 384);
    endtask

    // Change lane at a negedge; returns the cycle of the first erase pixel.
    task automatic set_lane(input int l, output int n);
        @(negedge clk);
        lane = 3'(l);
        n = cyc + 1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", q.size(), 0);
        @(negedge clk);
        #1;
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        push_phase(2, 2, cyc);
        push_done(cyc + 192);
    endtask

    initial begin
        int n;
        int p0;
        int d0;
        reset = 1'b1;
        lane  = 3'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_plot", int'(plot), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);

        // Initial paint at lane 2.
        release_reset();
        drain(400);
        repeat (10) @(negedge clk);

        // 2 -> 3, with lane 0 then 1 driven while busy; only lane 1 follows.
        set_lane(3, n);
        push_redraw(2, 3, n);
        repeat (50) @(negedge clk);
        lane = 3'd0;
        repeat (200) @(negedge clk);
        lane = 3'd1;
        push_redraw(3, 1, n + 386);
        drain(1200);

        // Illegal lanes while idle: no activity.
        for (int l = 5; l < 8; l++) begin
            lane = 3'(l);
            repeat (20) @(negedge clk);
            #1;
            chk("illegal_lane_busy", int'(busy), 0);
            chk("illegal_lane_plot", int'(plot), 0);
        end

        // Extreme lanes.
        set_lane(4, n);
        push_redraw(1, 4, n);
        drain(600);
        set_lane(0, n);
        push_redraw(4, 0, n);
        drain(600);

        // Reset in the middle of an erase.
        set_lane(3, n);
        push_redraw(0, 3, n);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 1);
        lane = 3'd2;
        repeat (3) @(posedge clk);
        release_reset();
        drain(400);

        // Same lane held: nothing happens.
        p0 = plot_cnt;
        d0 = done_cnt;
        repeat (1000) @(negedge clk);
        chk("idle_plots", plot_cnt - p0, 0);
        chk("idle_dones", done_cnt - d0, 0);
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
